timer_event_poller: RTL and testbench
=====================================

# timer_event_poller

Bus-side initiator for the timer peripheral's ready/ack capture protocol. It polls the peripheral's ready flag through the data/status select line, reads the 16-bit time value when an event is pending, and acknowledges it. Captured values go into a small first-word-fall-through FIFO that the CPU drains at its own pace. It sits between the timer and the CPU data bus, so software no longer has to spin on the status word.

## Interface
Parameters:
- POLL_GAP, 4: idle cycles between polls; must be ≥ 1.
- DEPTH, 8: FIFO entries; must be a power of 2, ≥ 2.
- AW, 3: log2(DEPTH).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dev_out  in  16  peripheral read bus: time value when dev_sel=0; {15'b0, ready} when dev_sel=1.
- dev_sel  out  1  peripheral select, driven to the timer's time-or-ready input; 1 selects status, 0 selects time.
- dev_ack  out  1  one-cycle acknowledge to the peripheral.
- pop  in  1  CPU consumes the head entry.
- data  out  16  head FIFO entry; 0 when empty.
- valid  out  1  FIFO not empty.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky flag: an event was acknowledged but dropped.
- clr_ovf  in  1  clears overflow.

## Operation
- FSM states: GAP, POLL, READ, ACK. Reset state is GAP with the gap counter at 0.
- GAP: the gap counter increments each cycle. When it reaches POLL_GAP-1, the counter clears and the FSM moves to POLL.
- POLL: dev_out[0] is sampled at the clock edge. If it is 1, go to READ. If it is 0, go to GAP.
- READ: dev_sel=0. dev_out is pushed into the FIFO at the clock edge. Go to ACK.
- ACK: dev_ack=1. Go to GAP.
- dev_sel is decoded from the state register: 0 in READ only, 1 in every other state. dev_ack is 1 in ACK only. Both are glitch-free state decodes.
- Only dev_out[0] is used in POLL. Bits [15:1] are ignored.
- FIFO: circular buffer with AW-bit read and write pointers that wrap modulo DEPTH, plus a separate count register.
- data = mem[rd_ptr] when valid, else 16'h0000.
- Push while full, without pop in the same cycle: the value is dropped, overflow is set, and ACK still occurs, so the peripheral is never stalled.
- Push and pop in the same cycle while full: both are performed, count is unchanged, overflow is not set.
- Push and pop in the same cycle while empty: the push is performed, the pop is ignored, and count becomes 1.
- Pop while empty: ignored; no pointer or count change.
- overflow: set has priority over clr_ovf in the same cycle. It is otherwise held until clr_ovf=1.
- Reset, asynchronous and at any point mid-operation: the FSM returns to GAP, the gap counter goes to 0, pointers and count go to 0, and overflow goes to 0.
- After reset outputs read: dev_sel=1, dev_ack=0, valid=0, data=0, count=0, overflow=0. FIFO memory is not reset.

## Timing
- Idle poll period is POLL_GAP+1 cycles, one of which is POLL.
- Event service is POLL → READ → ACK: 3 cycles. The full period with a pending event is POLL_GAP+3 cycles.
- Capture latency: the entry is visible on data/valid/count in the ACK cycle, i.e. the cycle after the READ edge.
- dev_ack is high for exactly one cycle per captured event and never in two consecutive cycles.
- The peripheral clears ready on the edge that ends ACK. The next POLL therefore observes a new event only.
- A ready that rises during GAP, READ or ACK is picked up at the next POLL; nothing is lost.
- Pop takes effect at the edge. The next entry, or 0 if empty, appears the following cycle.

## Test plan
- **Reset values:** assert rst_n=0 mid-READ → dev_sel=1 and dev_ack=0 immediately; after release, count=0, valid=0, data=0, and the first POLL occurs at cycle POLL_GAP.
- **No event:** hold dev_out=16'h0000 for 50 cycles with POLL_GAP=4 → dev_ack never asserts; dev_sel=0 never occurs.
- **Single event:** set ready, and set dev_out=16'h1234 while dev_sel=0 → dev_sel=0 for one cycle, dev_ack for one cycle; data=16'h1234, valid=1 and count=1 in the ACK cycle. pop → valid=0, data=0.
- **Ordering and wrap:** 10 events with values 1..10, DEPTH=8, popping after each event → data order is 1..10, pointers wrap, overflow=0.
- **Overflow:** 9 events with no pop → count=8, overflow=1, 9 acks issued, head=first value. clr_ovf and a 10th drop in the same cycle → overflow stays 1.
- **Full push with pop:** with the FIFO full, pop in the READ-edge cycle → count stays 8, overflow=0, and the new value is the tail entry.

Source files
------------

// File: rtl/timer_event_poller.sv
// timer_event_poller
//   Polls the timer peripheral's ready flag, reads the 16-bit time value when
//   an event is pending, acknowledges it, and queues the value in a small
//   first-word-fall-through FIFO that the CPU drains with pop.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   dev_out      : peripheral read bus (time when dev_sel=0, {15'b0,ready} when 1)
//   dev_sel      : peripheral select, 1 = status, 0 = time value
//   dev_ack      : one-cycle acknowledge to the peripheral
//   pop          : CPU consumes the head entry
//   data, valid  : head entry (0 when empty) and FIFO-not-empty
//   count        : number of stored entries, 0..DEPTH
//   overflow     : sticky, an acknowledged event was dropped; clr_ovf clears it
module timer_event_poller #(
   parameter int POLL_GAP = 4,
   parameter int DEPTH    = 8,
   parameter int AW       = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   dev_out,
   output logic          dev_sel,
   output logic          dev_ack,
   input  logic          pop,
   output logic [15:0]   data,
   output logic          valid,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          clr_ovf
);

   localparam int            GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_GAP, S_POLL, S_READ, S_ACK} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     mem [DEPTH];

   logic            push, full, pop_ok, wr_en, drop;

   // ---------------- poll FSM ----------------
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_POLL;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         // only the ready bit matters while status is selected
         S_POLL:  state_d = dev_out[0] ? S_READ : S_GAP;
         S_READ:  state_d = S_ACK;
         S_ACK:   state_d = S_GAP;
         default: state_d = S_GAP;
      endcase
   end

   // straight decodes of the state register, so no combinational glitches
   assign dev_sel = (state_q != S_READ);
   assign dev_ack = (state_q == S_ACK);

   // ---------------- FIFO ----------------
   always_comb begin
      push   = (state_q == S_READ);
      full   = (count_q == FULL_CNT);
      pop_ok = pop && (count_q != '0);
      // a pop in the same cycle frees the slot, so a full push still lands
      wr_en  = push && (!full || pop_ok);
      drop   = push && full && !pop_ok;

      wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop_ok);
      // set wins over clear
      ovf_d    = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_GAP;
         gap_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // storage is not reset; valid masks stale contents
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= dev_out;
   end

   assign valid    = (count_q != '0);
   assign data     = valid ? mem[rd_ptr_q] : 16'h0000;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_timer_event_poller.sv
// tb_timer_event_poller
//   Directed bench for timer_event_poller (POLL_GAP=4, DEPTH=8). A small
//   peripheral model answers dev_sel with either the ready bit or the time
//   value; a cycle table covers the first event, then hand sequences cover
//   idle polling, ordering/wrap, overflow, full push with pop and reset.
module tb_timer_event_poller;

   localparam int POLL_GAP = 4;
   localparam int DEPTH    = 8;
   localparam int AW       = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   dev_out;
   logic          dev_sel, dev_ack;
   logic          pop, clr_ovf;
   logic [15:0]   data;
   logic          valid;
   logic [AW:0]   count;
   logic          overflow;

   logic          ready;
   logic [15:0]   tval;

   int errors = 0;
   int checks = 0;
   int ack_cnt = 0;
   int ack_dbl = 0;
   int sel0_cnt = 0;
   logic ack_prev = 1'b0;

   timer_event_poller #(.POLL_GAP(POLL_GAP), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dev_out  (dev_out),
      .dev_sel  (dev_sel),
      .dev_ack  (dev_ack),
      .pop      (pop),
      .data     (data),
      .valid    (valid),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   // peripheral read mux
   assign dev_out = dev_sel ? {15'b0, ready} : tval;

   always @(posedge clk) begin
      if (dev_ack === 1'b1) ack_cnt++;
      if (dev_ack === 1'b1 && ack_prev === 1'b1) ack_dbl++;
      if (dev_sel === 1'b0) sel0_cnt++;
      ack_prev = dev_ack;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ready;
      logic        pop;
      logic        e_sel;
      logic        e_ack;
      logic        e_v;
      logic [15:0] e_data;
      logic [3:0]  e_cnt;
      logic        e_ovf;
   } vec_t;

   typedef struct {
      logic        ack;
      logic [15:0] data;
      logic [3:0]  cnt;
      logic        v;
      logic        ovf;
   } snap_t;

   // Raise ready with value v, wait for READ, optionally pop/clear during
   // READ, sample outputs in the ACK cycle, optionally pop during ACK.
   task automatic do_event(input logic [15:0] v, input logic pop_rd, input logic clr_rd,
                           input logic pop_ack, output snap_t s);
      int n;
      n = 0;
      ready = 1'b1;
      tval  = v;
      while (dev_sel !== 1'b0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("reach_read", {31'b0, dev_sel}, 32'd0);
      pop     = pop_rd;
      clr_ovf = clr_rd;
      @(negedge clk); #1;
      pop     = 1'b0;
      clr_ovf = 1'b0;
      ready   = 1'b0;
      s.ack   = dev_ack;
      s.data  = data;
      s.cnt   = count;
      s.v     = valid;
      s.ovf   = overflow;
      pop     = pop_ack;
      @(negedge clk); #1;
      pop     = 1'b0;
   endtask

   vec_t  vecs [13];
   snap_t s;
   int    a0, s0, n;
   logic [15:0] exp_q [8];

   initial begin
      // cycle k = k-th cycle after reset release; POLL at 4, READ 5, ACK 6
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 4'd1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 4'd1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};

      rst_n   = 1'b0;
      pop     = 1'b0;
      clr_ovf = 1'b0;
      tval    = 16'h1234;
      ready   = vecs[0].ready;
      #12;
      @(negedge clk);
      rst_n = 1'b1;

      // ---- single event, pop, pop while empty ----
      for (int i = 0; i < 13; i++) begin
         if (i != 0) @(negedge clk);
         ready = vecs[i].ready;
         pop   = vecs[i].pop;
         #1;
         chk($sformatf("vec%0d", i),
             {8'b0, dev_sel, dev_ack, valid, data, count, overflow},
             {8'b0, vecs[i].e_sel, vecs[i].e_ack, vecs[i].e_v, vecs[i].e_data,
              vecs[i].e_cnt, vecs[i].e_ovf});
      end
      pop = 1'b0;

      // ---- no event for 50 cycles ----
      ready = 1'b0;
      tval  = 16'h0000;
      a0 = ack_cnt;
      s0 = sel0_cnt;
      repeat (50) @(negedge clk);
      #1;
      chk("idle_acks", ack_cnt - a0, 0);
      chk("idle_sel0", sel0_cnt - s0, 0);

      // ---- ordering and pointer wrap ----
      for (int i = 1; i <= 10; i++) begin
         do_event(16'(i), 1'b0, 1'b0, 1'b1, s);
         chk($sformatf("wrap_ack%0d", i), {31'b0, s.ack}, 32'd1);
         chk($sformatf("wrap_data%0d", i), {16'b0, s.data}, i);
      end
      chk("wrap_ovf", {31'b0, overflow}, 32'd0);
      chk("wrap_cnt", {28'b0, count}, 32'd0);

      // ---- overflow: 9 events, no pop ----
      a0 = ack_cnt;
      for (int i = 0; i < 9; i++) begin
         do_event(16'(100 + i), 1'b0, 1'b0, 1'b0, s);
      end
      chk("ovf_acks", ack_cnt - a0, 9);
      chk("ovf_cnt", {28'b0, count}, 32'd8);
      chk("ovf_flag", {31'b0, overflow}, 32'd1);
      chk("ovf_head", {16'b0, data}, 32'd100);
      // clear coincides with a 10th drop: set wins
      do_event(16'd109, 1'b0, 1'b1, 1'b0, s);
      chk("ovf_set_wins", {31'b0, s.ovf}, 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk); #1;
      clr_ovf = 1'b0;
      chk("ovf_cleared", {31'b0, overflow}, 32'd0);

      // ---- full push with pop in the READ-edge cycle ----
      do_event(16'hBEEF, 1'b1, 1'b0, 1'b0, s);
      chk("fpp_cnt", {28'b0, s.cnt}, 32'd8);
      chk("fpp_ovf", {31'b0, s.ovf}, 32'd0);
      chk("fpp_head", {16'b0, s.data}, 32'd101);
      for (int i = 0; i < 7; i++) exp_q[i] = 16'(101 + i);
      exp_q[7] = 16'hBEEF;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d", i), {16'b0, data}, {16'b0, exp_q[i]});
         pop = 1'b1;
         @(negedge clk); #1;
      end
      pop = 1'b0;
      chk("drain_empty", {11'b0, valid, data, count}, 32'd0);

      // ---- reset mid-READ ----
      do_event(16'h5555, 1'b0, 1'b0, 1'b0, s);
      chk("pre_rst_cnt", {28'b0, count}, 32'd1);
      ready = 1'b1;
      tval  = 16'h6666;
      n = 0;
      while (dev_sel !== 1'b0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("rst_reach_read", {31'b0, dev_sel}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_outputs", {10'b0, dev_sel, dev_ack, valid, data, count, overflow},
          {10'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      #1;
      while (dev_sel !== 1'b0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      // POLL in cycle POLL_GAP, READ one cycle later
      chk("first_read_cycle", n, POLL_GAP + 1);
      ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_cnt", {28'b0, count}, 32'd1);
      chk("ack_no_back2back", ack_dbl, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
